// File: rtl/apb_stdout_initiator.sv
// apb_stdout_initiator: buffers per-core character print requests in a small
// FIFO and drains them as single-beat APB writes to the stdout peripheral.
// Requests outside the configured cluster/core range are consumed and dropped.
// PSLVERR responses are counted in a saturating 8-bit counter.
//
// Request handshake: a request is transferred on a rising clock edge where
// req_valid_i && req_ready_o. req_ready_o is a register reflecting "FIFO not
// full" and never depends combinationally on req_valid_i. The requester holds
// its payload stable while req_valid_i is high and ready is low. An
// out-of-range request still completes the handshake; it is then discarded.
module apb_stdout_initiator #(
    parameter int unsigned            N_CORES    = 8,
    parameter int unsigned            N_CLUSTERS = 4,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h1A10_F000),
    parameter int unsigned            FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_cluster_i,
    input  logic [3:0]            req_core_i,
    input  logic [7:0]            req_char_i,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    output logic [7:0]            slverr_cnt_o,
    output logic                  idle_o,
    output logic [1:0]            dbg_state_o
);

    localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [4:0]      N_CLUSTERS_L = 5'(N_CLUSTERS);
    localparam logic [4:0]      N_CORES_L    = 5'(N_CORES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] cluster;
        logic [3:0] core;
        logic [7:0] chr;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ready_q, ready_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             accept;
    logic             in_range;
    logic             push;
    logic             pop;
    entry_t           head;
    entry_t           entry_in;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic             unused_prdata;

    // Read data is never used by a write-only initiator.
    assign unused_prdata = ^prdata_i;

    assign accept   = req_valid_i && ready_q;
    assign in_range = ({1'b0, req_cluster_i} < N_CLUSTERS_L) &&
                      ({1'b0, req_core_i} < N_CORES_L);
    assign push     = accept && in_range;
    assign pop      = (state_q == ST_ACCESS) && pready_i;
    assign head     = mem_q[rd_ptr_q];
    assign entry_in = '{cluster: req_cluster_i, core: req_core_i, chr: req_char_i};

    // FIFO pointer, occupancy, ready and error-counter next-state logic.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
        ready_d = (count_d != FULL_CNT);
        if (pop && pslverr_i && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // APB phase sequencing; a push seen in IDLE starts SETUP on the next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_d != '0) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) state_d = (count_d != '0) ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset discards all buffered requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    // APB outputs decoded from the phase and the FIFO head.
    always_comb begin
        psel_o    = (state_q != ST_IDLE);
        penable_o = (state_q == ST_ACCESS);
        pwrite_o  = psel_o;
        addr_off  = '0;
        addr_off[10:7] = head.cluster;
        addr_off[6:3]  = head.core;
        paddr_o   = '0;
        pwdata_o  = '0;
        if (psel_o) begin
            paddr_o       = BASE_ADDR | addr_off;
            pwdata_o[7:0] = head.chr;
        end
    end

    assign req_ready_o  = ready_q;
    assign slverr_cnt_o = err_cnt_q;
    assign idle_o       = (count_q == '0) && (state_q == ST_IDLE);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_apb_stdout_initiator.sv
// Directed bench for apb_stdout_initiator with hand-computed expected values.
module tb_apb_stdout_initiator;

    logic        clk;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_cluster_i;
    logic [3:0]  req_core_i;
    logic [7:0]  req_char_i;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;
    logic [7:0]  slverr_cnt_o;
    logic        idle_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          comp_cyc_q[$];

    apb_stdout_initiator dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_cluster_i(req_cluster_i),
        .req_core_i   (req_core_i),
        .req_char_i   (req_char_i),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pwrite_o     (pwrite_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .slverr_cnt_o (slverr_cnt_o),
        .idle_o       (idle_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Completed-transfer monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_ni && psel_o && penable_o && pready_i) begin
            obs_q.push_back({paddr_o, pwdata_o});
            comp_cyc_q.push_back(cyc_cnt);
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] cl, input logic [3:0] co, input logic [7:0] ch);
        int guard;
        guard = 0;
        req_valid_i   = 1'b1;
        req_cluster_i = cl;
        req_core_i    = co;
        req_char_i    = ch;
        while (!req_ready_o && guard < 500) begin
            cyc();
            guard++;
        end
        check_eq("send_ready", {63'd0, req_ready_o}, 64'd1);
        cyc();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (!idle_o && guard < 1000) begin
            cyc();
            guard++;
        end
        check_eq(tag, {63'd0, idle_o}, 64'd1);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (obs_q.size() < exp_q.size() && guard < 500) begin
            cyc();
            guard++;
        end
        check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check_eq(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_phase(input string tag, input logic sel, input logic en,
                               input logic [31:0] addr, input logic [31:0] data);
        check_eq({tag, "_psel"},    {63'd0, psel_o},    {63'd0, sel});
        check_eq({tag, "_penable"}, {63'd0, penable_o}, {63'd0, en});
        check_eq({tag, "_pwrite"},  {63'd0, pwrite_o},  {63'd0, sel});
        check_eq({tag, "_paddr"},   {32'd0, paddr_o},   {32'd0, addr});
        check_eq({tag, "_pwdata"},  {32'd0, pwdata_o},  {32'd0, data});
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_cluster_i = 4'd0;
        req_core_i    = 4'd0;
        req_char_i    = 8'd0;
        prdata_i      = 32'd0;
        pready_i      = 1'b1;
        pslverr_i     = 1'b0;

        // Reset values
        cyc();
        cyc();
        check_phase("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("rst_ready", {63'd0, req_ready_o}, 64'd0);
        check_eq("rst_idle", {63'd0, idle_o}, 64'd1);
        check_eq("rst_errcnt", {56'd0, slverr_cnt_o}, 64'd0);
        check_eq("rst_state", {62'd0, dbg_state_o}, 64'd0);
        rst_ni = 1'b1;
        check_eq("rst_rel_ready", {63'd0, req_ready_o}, 64'd0);
        cyc();
        check_eq("post_rst_ready", {63'd0, req_ready_o}, 64'd1);
        check_eq("post_rst_idle", {63'd0, idle_o}, 64'd1);

        // Single request, zero wait states
        pready_i = 1'b1;
        exp_q.push_back({32'h1A10_F090, 32'h0000_0041});
        send(4'd1, 4'd2, 8'h41);
        check_phase("t1_setup", 1'b1, 1'b0, 32'h1A10_F090, 32'h41);
        check_eq("t1_setup_state", {62'd0, dbg_state_o}, 64'd1);
        check_eq("t1_setup_idle", {63'd0, idle_o}, 64'd0);
        cyc();
        check_phase("t1_access", 1'b1, 1'b1, 32'h1A10_F090, 32'h41);
        check_eq("t1_access_state", {62'd0, dbg_state_o}, 64'd2);
        cyc();
        check_phase("t1_done", 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("t1_done_idle", {63'd0, idle_o}, 64'd1);
        drain("t1_xfer");

        // Burst fills FIFO under stall
        comp_cyc_q.delete();
        pready_i = 1'b0;
        exp_q.push_back({32'h1A10_F100, 32'h41});
        exp_q.push_back({32'h1A10_F108, 32'h42});
        exp_q.push_back({32'h1A10_F110, 32'h43});
        exp_q.push_back({32'h1A10_F118, 32'h44});
        exp_q.push_back({32'h1A10_F120, 32'h45});
        exp_q.push_back({32'h1A10_F128, 32'h46});
        send(4'd2, 4'd0, 8'h41);
        send(4'd2, 4'd1, 8'h42);
        send(4'd2, 4'd2, 8'h43);
        send(4'd2, 4'd3, 8'h44);
        check_eq("t2_full_ready", {63'd0, req_ready_o}, 64'd0);
        check_phase("t2_stall", 1'b1, 1'b1, 32'h1A10_F100, 32'h41);
        cyc();
        check_eq("t2_full_ready2", {63'd0, req_ready_o}, 64'd0);
        check_phase("t2_stall2", 1'b1, 1'b1, 32'h1A10_F100, 32'h41);
        pready_i = 1'b1;
        cyc();
        check_eq("t2_ready_back", {63'd0, req_ready_o}, 64'd1);
        check_phase("t2_next_setup", 1'b1, 1'b0, 32'h1A10_F108, 32'h42);
        send(4'd2, 4'd4, 8'h45);
        send(4'd2, 4'd5, 8'h46);
        drain("t2_xfer");
        check_eq("t2_ncomp", 64'(comp_cyc_q.size()), 64'd6);
        for (int i = 0; i + 1 < comp_cyc_q.size(); i++) begin
            check_eq("t2_gap", 64'(comp_cyc_q[i+1] - comp_cyc_q[i]), 64'd2);
        end
        wait_idle("t2_idle");
        check_eq("t2_errcnt", {56'd0, slverr_cnt_o}, 64'd0);

        // Wait states: 3 stalled ACCESS cycles then completion
        pready_i = 1'b0;
        exp_q.push_back({32'h1A10_F1B8, 32'h0A});
        send(4'd3, 4'd7, 8'h0A);
        check_phase("t3_setup", 1'b1, 1'b0, 32'h1A10_F1B8, 32'h0A);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_phase("t3_wait", 1'b1, 1'b1, 32'h1A10_F1B8, 32'h0A);
        end
        cyc();
        pready_i = 1'b1;
        check_phase("t3_last", 1'b1, 1'b1, 32'h1A10_F1B8, 32'h0A);
        cyc();
        check_eq("t3_idle", {63'd0, idle_o}, 64'd1);
        check_eq("t3_psel_off", {63'd0, psel_o}, 64'd0);
        drain("t3_xfer");

        // Out-of-range requests are consumed and dropped
        send(4'd4, 4'd0, 8'h58);
        check_eq("t4_psel_a", {63'd0, psel_o}, 64'd0);
        check_eq("t4_idle_a", {63'd0, idle_o}, 64'd1);
        send(4'd0, 4'd15, 8'h59);
        send(4'd15, 4'd8, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_psel", {63'd0, psel_o}, 64'd0);
            check_eq("t4_idle", {63'd0, idle_o}, 64'd1);
            cyc();
        end
        check_eq("t4_no_xfer", 64'(obs_q.size()), 64'd0);

        // Error counting and saturation
        pslverr_i = 1'b1;
        for (int i = 0; i < 3; i++) send(4'd0, 4'd0, 8'h30);
        wait_idle("t5_idle_a");
        check_eq("t5_errcnt_3", {56'd0, slverr_cnt_o}, 64'd3);
        check_eq("t5_nxfer_a", 64'(obs_q.size()), 64'd3);
        obs_q.delete();
        pslverr_i = 1'b0;
        for (int i = 0; i < 2; i++) send(4'd1, 4'd1, 8'h31);
        wait_idle("t5_idle_b");
        check_eq("t5_errcnt_hold", {56'd0, slverr_cnt_o}, 64'd3);
        pslverr_i = 1'b1;
        for (int i = 0; i < 252; i++) send(4'd0, 4'd1, 8'h32);
        wait_idle("t5_idle_c");
        check_eq("t5_errcnt_255", {56'd0, slverr_cnt_o}, 64'd255);
        for (int i = 0; i < 45; i++) send(4'd0, 4'd1, 8'h33);
        wait_idle("t5_idle_d");
        check_eq("t5_errcnt_sat", {56'd0, slverr_cnt_o}, 64'd255);
        check_eq("t5_nxfer_b", 64'(obs_q.size()), 64'd299);
        obs_q.delete();
        pslverr_i = 1'b0;

        // Reset mid-transfer with 3 entries queued
        pready_i = 1'b0;
        send(4'd1, 4'd0, 8'h61);
        send(4'd1, 4'd1, 8'h62);
        send(4'd1, 4'd2, 8'h63);
        check_eq("t6_access_pen", {63'd0, penable_o}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_phase("t6_async", 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("t6_rst_ready", {63'd0, req_ready_o}, 64'd0);
        check_eq("t6_rst_idle", {63'd0, idle_o}, 64'd1);
        check_eq("t6_rst_errcnt", {56'd0, slverr_cnt_o}, 64'd0);
        cyc();
        cyc();
        rst_ni   = 1'b1;
        pready_i = 1'b1;
        cyc();
        check_eq("t6_rel_ready", {63'd0, req_ready_o}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("t6_no_psel", {63'd0, psel_o}, 64'd0);
            check_eq("t6_idle", {63'd0, idle_o}, 64'd1);
            cyc();
        end
        check_eq("t6_no_replay", 64'(obs_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_stdout_initiator.md
# apb_stdout_initiator

APB master that turns per-core character-print requests into single-beat APB write transfers toward the simulation stdout peripheral. It sits between the cluster-side print request path and the peripheral APB bus. Requests are buffered in a small FIFO and drained one APB write at a time; PSLVERR responses are counted.

## Interface
- `N_CORES`, default 8: cores per cluster; valid core indices are 0..N_CORES-1, max 16.
- `N_CLUSTERS`, default 4: valid cluster indices are 0..N_CLUSTERS-1, max 16.
- `ADDR_WIDTH`, default 32: APB address width.
- `DATA_WIDTH`, default 32: APB data width, at least 8.
- `BASE_ADDR`, default 32'h1A10_F000: base of the stdout window; bits [10:0] must be zero.
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, at least 2.

Ports (clock and reset first):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid_i` in 1: print request valid.
- `req_ready_o` out 1: request accepted when valid && ready.
- `req_cluster_i` in 4: cluster index.
- `req_core_i` in 4: core index.
- `req_char_i` in 8: character byte.
- `paddr_o` out ADDR_WIDTH: APB address.
- `pwdata_o` out DATA_WIDTH: APB write data.
- `pwrite_o` out 1: APB write flag.
- `psel_o` out 1: APB select.
- `penable_o` out 1: APB enable.
- `prdata_i` in DATA_WIDTH: APB read data; ignored.
- `pready_i` in 1: APB ready.
- `pslverr_i` in 1: APB slave error.
- `slverr_cnt_o` out 8: saturating count of errored transfers.
- `idle_o` out 1: high when the FIFO is empty and the FSM is in IDLE.

## Operation
- **Acceptance**
  - `req_ready_o` = FIFO not full, registered from FIFO state.
  - There is no pass-through: a push while full is not possible.
  - A push and a pop in the same cycle are both legal and leave the occupancy unchanged.
- **Range filter**
  - An accepted request with cluster ≥ N_CLUSTERS or core ≥ N_CORES is consumed and dropped.
  - A dropped request is not pushed and causes no APB transfer.
- **Address and data**
  - Address = BASE_ADDR | (cluster << 7) | (core << 3). The cluster field is bits [10:7] and the core field is bits [6:3].
  - Data = the character zero-extended to DATA_WIDTH.
  - The character 0x0A is forwarded like any other byte. Line assembly belongs to the peripheral.
- **FSM states**
  - IDLE: psel=0, penable=0. Go to SETUP when the FIFO is non-empty.
  - SETUP: psel=1, penable=0, with address and data from the FIFO head. Always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. Hold all signals while pready=0. When pready=1, pop the head, sample pslverr, then go to SETUP if more entries remain, otherwise IDLE.
- **APB output rules**
  - `pwrite_o` = 1 whenever psel=1, and 0 otherwise.
  - paddr/pwdata are driven from the FIFO head register and do not change between SETUP and the completing ACCESS cycle.
- **Error counter**
  - Increments by 1 on each completing ACCESS cycle with pslverr=1.
  - Saturates at 255. It does not wrap.
- **Reset values**
  - All outputs 0, except `req_ready_o`=0 during reset and 1 from the first clock edge after deassertion.
  - `idle_o`=1.
  - FIFO empty, FSM in IDLE.
- **Reset mid-transfer**
  - psel/penable drop asynchronously.
  - Buffered requests are discarded and not replayed.

## Timing
- A request accepted at edge t is visible at the FIFO head after t. SETUP is presented in cycle t+1 and ACCESS in t+2.
- With pready=1, the transfer completes at the end of t+2. Minimum latency is 2 cycles after acceptance.
- Back-to-back transfers take 2 cycles each, with no IDLE cycle between them.
- Each wait state (pready=0 in ACCESS) adds exactly 1 cycle.
- With the FIFO full during a stall, req_ready_o returns high the cycle after the completing ACCESS.
- `idle_o` goes high the cycle after the last completing ACCESS.

## Test plan
- **Single request, zero wait states.** Request cluster 1, core 2, char 0x41, pready=1 → one transfer. Expect paddr=BASE+0x090, pwdata=0x41, SETUP at t+1, ACCESS at t+2, idle_o=1 at t+3.
- **Burst fills FIFO under stall.** Push 6 requests 'A'..'F' with pready held 0, FIFO_DEPTH=4 → req_ready_o falls after the 4th accepted request. Release pready → 6 transfers in order, 2 cycles each with no gaps, and no request lost.
- **Wait states.** pready=0 for 3 cycles in ACCESS → psel, penable, paddr and pwdata stay stable for 4 ACCESS cycles; exactly one pop.
- **Out-of-range request.** cluster=N_CLUSTERS, or core=15 with N_CORES=8 → accepted, psel stays 0, idle_o stays 1.
- **Error counting.** 300 transfers with pslverr=1 → slverr_cnt_o=255. Transfers with pslverr=0 → counter unchanged.
- **Reset mid-transfer.** Assert rst_ni low during ACCESS with 3 entries queued → psel/penable=0 immediately. After release: idle_o=1, no transfers issued.
